// File: rtl/led_scan_pkg.sv
// Shared constants and state encoding for the LED panel framebuffer scanout.
package led_scan_pkg;

  localparam int unsigned NumCols = 64;
  localparam int unsigned NumRows = 16;
  localparam int unsigned ColW    = 6;
  localparam int unsigned RowW    = 4;
  localparam int unsigned AddrW   = 1 + RowW + ColW;

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StShift,
    StTail,
    StLatch,
    StDisplay
  } scan_state_e;

endpackage

// File: rtl/framebuffer_scanout.sv
// Scans a double-buffered framebuffer onto a 1/16-scan HUB75-style panel.
// Every output is a register driven from the next-state values.
module framebuffer_scanout
  import led_scan_pkg::*;
#(
  parameter int ON_CYCLES = 64,
  parameter int COLS      = NumCols,
  parameter int ROWS      = NumRows
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  output logic [AddrW-1:0] rd_addr,
  output logic             rd_en,
  input  logic [1:0]       rd_data,
  output logic             panel_r1,
  output logic             panel_r2,
  output logic             panel_clk,
  output logic             panel_lat,
  output logic             panel_oe_n,
  output logic [RowW-1:0]  panel_row,
  input  logic             swap_req,
  output logic             swap_ack,
  output logic             frame_done,
  output logic             active_buf
);

  localparam int unsigned OnCyc = (ON_CYCLES < 1) ? 1 : ON_CYCLES;
  localparam int unsigned CntW  = (OnCyc > 1) ? $clog2(OnCyc) : 1;

  scan_state_e     state_q, state_d;
  logic [RowW-1:0] row_q, row_d;
  logic [ColW-1:0] col_q, col_d;
  logic            phase_q, phase_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            buf_d;

  logic [AddrW-1:0] rd_addr_d;
  logic             rd_en_d, r1_d, r2_d, pclk_d, lat_d, oe_n_d, swap_ack_d, frame_done_d;
  logic [RowW-1:0]  panel_row_d;

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    phase_d      = phase_q;
    cnt_d        = cnt_q;
    buf_d        = active_buf;
    swap_ack_d   = 1'b0;
    frame_done_d = 1'b0;

    unique case (state_q)
      StIdle: if (enable) state_d = StPre;
      StPre: begin
        state_d = StShift;
        col_d   = '0;
        phase_d = 1'b0;
      end
      StShift: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else if (col_q == ColW'(COLS - 1)) begin
          state_d = StTail;
        end else begin
          phase_d = 1'b0;
          col_d   = ColW'(col_q + 1'b1);
        end
      end
      StTail:  state_d = StLatch;
      StLatch: begin
        state_d = StDisplay;
        cnt_d   = '0;
      end
      StDisplay: begin
        if (cnt_q == CntW'(OnCyc - 1)) begin
          if (row_q == RowW'(ROWS - 1)) begin
            row_d        = '0;
            frame_done_d = 1'b1;
            // Buffer swap only happens at the frame boundary, sampled once per frame.
            if (swap_req) begin
              buf_d      = ~active_buf;
              swap_ack_d = 1'b1;
            end
          end else begin
            row_d = RowW'(row_q + 1'b1);
          end
          state_d = enable ? StPre : StIdle;
        end else begin
          cnt_d = CntW'(cnt_q + 1'b1);
        end
      end
      default: state_d = StIdle;
    endcase

    rd_addr_d   = rd_addr;
    rd_en_d     = 1'b0;
    r1_d        = panel_r1;
    r2_d        = panel_r2;
    pclk_d      = 1'b0;
    lat_d       = 1'b0;
    oe_n_d      = 1'b1;
    panel_row_d = panel_row;

    unique case (state_d)
      StIdle: ;
      StPre: begin
        rd_addr_d = {buf_d, row_d, ColW'(0)};
        rd_en_d   = 1'b1;
      end
      StShift: begin
        if (!phase_d) begin
          pclk_d = (col_d != '0);
        end else begin
          // Data changes on the falling panel_clk edge; the panel samples on the next rise.
          r1_d = rd_data[0];
          r2_d = rd_data[1];
          if (col_d != ColW'(COLS - 1)) begin
            rd_addr_d = {buf_d, row_d, ColW'(col_d + 1'b1)};
            rd_en_d   = 1'b1;
          end
        end
      end
      StTail:  pclk_d = 1'b1;
      StLatch: begin
        lat_d       = 1'b1;
        panel_row_d = row_d;
      end
      StDisplay: oe_n_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      row_q      <= '0;
      col_q      <= '0;
      phase_q    <= 1'b0;
      cnt_q      <= '0;
      active_buf <= 1'b0;
      rd_addr    <= '0;
      rd_en      <= 1'b0;
      panel_r1   <= 1'b0;
      panel_r2   <= 1'b0;
      panel_clk  <= 1'b0;
      panel_lat  <= 1'b0;
      panel_oe_n <= 1'b1;
      panel_row  <= '0;
      swap_ack   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      active_buf <= buf_d;
      rd_addr    <= rd_addr_d;
      rd_en      <= rd_en_d;
      panel_r1   <= r1_d;
      panel_r2   <= r2_d;
      panel_clk  <= pclk_d;
      panel_lat  <= lat_d;
      panel_oe_n <= oe_n_d;
      panel_row  <= panel_row_d;
      swap_ack   <= swap_ack_d;
      frame_done <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Directed bench for framebuffer_scanout: reset, shift data, row/frame timing,
// buffer swap, enable drop and mid-row reset.
module tb_framebuffer_scanout;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [10:0] rd_addr;
  logic        rd_en;
  logic [1:0]  rd_data = '0;
  logic        panel_r1, panel_r2, panel_clk, panel_lat, panel_oe_n;
  logic [3:0]  panel_row;
  logic        swap_req;
  logic        swap_ack, frame_done, active_buf;

  int n_checks = 0;
  int n_errors = 0;

  int          cyc = 0;
  int          rises = 0;
  int          oe_low = 0;
  int          fd_cnt = 0;
  int          fd_last = 0;
  int          fd_prev = 0;
  logic [10:0] fd_addr = '0;
  int          ack_cnt = 0;
  int          ack_cyc = 0;
  logic        prev_clk = 1'b0;
  int          last_lat = 0;

  framebuffer_scanout #(.ON_CYCLES(64)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .rd_addr    (rd_addr),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .panel_r1   (panel_r1),
    .panel_r2   (panel_r2),
    .panel_clk  (panel_clk),
    .panel_lat  (panel_lat),
    .panel_oe_n (panel_oe_n),
    .panel_row  (panel_row),
    .swap_req   (swap_req),
    .swap_ack   (swap_ack),
    .frame_done (frame_done),
    .active_buf (active_buf)
  );

  always #5 clk = ~clk;

  // RAM model: column c holds c[1:0] (bit0 upper pixel, bit1 lower pixel).
  always @(posedge clk) if (rd_en) rd_data <= rd_addr[1:0];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    logic [1:0] exp_px;
    @(posedge clk);
    #1;
    cyc++;
    if (!panel_oe_n) oe_low++;
    if (panel_clk && !prev_clk) begin
      rises++;
      exp_px = 2'(rises - 1);
      check("shift_data", {30'd0, panel_r2, panel_r1}, {30'd0, exp_px});
    end
    prev_clk = panel_clk;
    if (frame_done) begin
      fd_prev = fd_last;
      fd_last = cyc;
      fd_addr = rd_addr;
      fd_cnt++;
    end
    if (swap_ack) begin
      ack_cnt++;
      ack_cyc  = cyc;
      swap_req = 1'b0;
    end
  endtask

  task automatic wait_lat();
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 400 && !seen; n++) begin
      step();
      if (panel_lat) seen = 1'b1;
    end
    check("lat_seen", {31'd0, seen}, 32'd1);
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, "_rd_addr"}, {21'd0, rd_addr}, 32'd0);
    check({tag, "_rd_en"}, {31'd0, rd_en}, 32'd0);
    check({tag, "_pixels"}, {30'd0, panel_r2, panel_r1}, 32'd0);
    check({tag, "_pclk"}, {31'd0, panel_clk}, 32'd0);
    check({tag, "_lat"}, {31'd0, panel_lat}, 32'd0);
    check({tag, "_oe_n"}, {31'd0, panel_oe_n}, 32'd1);
    check({tag, "_row"}, {28'd0, panel_row}, 32'd0);
    check({tag, "_buf"}, {31'd0, active_buf}, 32'd0);
    check({tag, "_pulses"}, {30'd0, swap_ack, frame_done}, 32'd0);
  endtask

  // Waits for `nrows` latch pulses, checking per-row timing; row numbering continues from start_row.
  task automatic scan_rows(input int start_row, input int nrows, input int swap_at, input logic pulse);
    for (int i = 1; i <= nrows; i++) begin
      wait_lat();
      check("lat_period", cyc - last_lat, 32'd195);
      check("oe_low_cycles", oe_low, 32'd64);
      check("clk_rises", rises, 32'd64);
      check("panel_row", {28'd0, panel_row}, (start_row + i) % 16);
      last_lat = cyc;
      oe_low   = 0;
      rises    = 0;
      if (i == swap_at) begin
        swap_req = 1'b1;
        if (pulse) begin
          step();
          swap_req = 1'b0;
        end
      end
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    enable   = 1'b0;
    swap_req = 1'b0;
    repeat (3) step();
    check_idle_reset("reset");

    reset_n = 1'b1;
    repeat (5) step();
    check("idle_oe_n", {31'd0, panel_oe_n}, 32'd1);
    check("idle_rd_en", {31'd0, rd_en}, 32'd0);
    check("idle_pclk", {31'd0, panel_clk}, 32'd0);

    enable = 1'b1;
    step();
    check("pre_rd_en", {31'd0, rd_en}, 32'd1);
    check("pre_addr", {21'd0, rd_addr}, 32'h000);

    // First row: 64 rises with walking column data, then one latch.
    wait_lat();
    check("row0_rises", rises, 32'd64);
    check("row0_panel_row", {28'd0, panel_row}, 32'd0);
    last_lat = cyc;
    oe_low   = 0;
    rises    = 0;

    scan_rows(0, 16, 0, 1'b0);
    check("f1_done_cnt", fd_cnt, 32'd1);
    check("f1_done_addr", {21'd0, fd_addr}, 32'h000);
    check("f1_no_ack", ack_cnt, 32'd0);
    check("f1_buf", {31'd0, active_buf}, 32'd0);

    // Held swap request raised during row 5.
    scan_rows(0, 16, 5, 1'b0);
    check("f2_done_cnt", fd_cnt, 32'd2);
    check("frame_period", fd_last - fd_prev, 32'd3120);
    check("f2_ack_cnt", ack_cnt, 32'd1);
    check("ack_with_done", ack_cyc, fd_last);
    check("f2_swap_addr", {21'd0, fd_addr}, 32'h400);
    check("f2_buf", {31'd0, active_buf}, 32'd1);

    // One-cycle request mid-frame must be ignored.
    scan_rows(0, 16, 7, 1'b1);
    check("f3_done_cnt", fd_cnt, 32'd3);
    check("f3_ack_cnt", ack_cnt, 32'd1);
    check("f3_buf", {31'd0, active_buf}, 32'd1);
    check("f3_addr", {21'd0, fd_addr}, 32'h400);

    // Drop enable during SHIFT of row 3.
    scan_rows(0, 2, 0, 1'b0);
    repeat (70) step();
    enable = 1'b0;
    wait_lat();
    check("drop_row", {28'd0, panel_row}, 32'd3);
    check("drop_rises", rises, 32'd64);
    oe_low = 0;
    rises  = 0;
    repeat (150) step();
    check("drop_oe_cycles", oe_low, 32'd64);
    check("drop_idle_oe_n", {31'd0, panel_oe_n}, 32'd1);
    check("drop_idle_rd_en", {31'd0, rd_en}, 32'd0);
    check("drop_no_shift", rises, 32'd0);

    enable = 1'b1;
    step();
    check("reen_rd_en", {31'd0, rd_en}, 32'd1);
    check("reen_addr", {21'd0, rd_addr}, 32'h500);

    // Reset during column 30 of row 4.
    repeat (61) step();
    check("mid_rises", rises, 32'd30);
    #2 reset_n = 1'b0;
    #1;
    check_idle_reset("midreset");
    step();
    reset_n = 1'b1;
    rises   = 0;
    step();
    check("restart_rd_en", {31'd0, rd_en}, 32'd1);
    check("restart_addr", {21'd0, rd_addr}, 32'h000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/framebuffer_scanout.md
FRAMEBUFFER_SCANOUT -- requirements
Module: framebuffer_scanout

Interface
REQ-001 Parameter ON_CYCLES, default 64, meaning: display (OE active) cycles per row; values below 1 SHALL be treated as 1.
REQ-002 Parameter COLS, default 64, meaning: pixels shifted per row; fixed at 64 (6-bit column index).
REQ-003 Parameter ROWS, default 16, meaning: row-pairs per frame; fixed at 16 (4-bit row index).
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 enable  input  1  level; 1 = scan frames, 0 = stop at next row boundary.
REQ-007 rd_addr  output  11  framebuffer read address {active_buf, row[3:0], col[5:0]}.
REQ-008 rd_en  output  1  framebuffer read clock-enable; drives the RAM read-port enable.
REQ-009 rd_data  input  2  RAM registered read data, valid the cycle after rd_en=1; bit0 upper-half pixel, bit1 lower-half pixel.
REQ-010 panel_r1, panel_r2  output  1 each  serial pixel data, upper and lower half.
REQ-011 panel_clk, panel_lat  output  1 each  panel shift clock and latch strobe.
REQ-012 panel_oe_n  output  1  panel output enable, active-low.
REQ-013 panel_row  output  4  row-pair address currently displayed.
REQ-014 swap_req  input  1  level request to swap framebuffer halves; held until swap_ack.
REQ-015 swap_ack, frame_done  output  1 each  single-cycle pulses.
REQ-016 active_buf  output  1  buffer half being read; writers SHALL target ~active_buf.

Function
REQ-017 States: IDLE, PRE, SHIFT (phase 0/1 per column), TAIL, LATCH, DISPLAY; all outputs registered.
REQ-018 IDLE: panel_oe_n=1, rd_en=0, panel_clk=0, panel_lat=0; enter PRE with row=0 when enable=1.
REQ-019 PRE (1 cycle): rd_addr={active_buf,row,0}, rd_en=1, panel_clk=0.
REQ-020 SHIFT phase 0 of column c: rd_en=0 (rd_data held), panel_clk=1 if c>0 else 0.
REQ-021 SHIFT phase 1 of column c: panel_r1/r2 <= rd_data[0]/rd_data[1]; panel_clk=0; if c<63 rd_addr=col c+1 and rd_en=1, else rd_en=0.
REQ-022 Data SHALL change only entering phase 1 (panel_clk falling); panel samples on panel_clk rising entering phase 0 of c+1 or TAIL.
REQ-023 TAIL (1 cycle): panel_clk=1, final rising edge for column 63.
REQ-024 LATCH (1 cycle): panel_lat=1, panel_clk=0, panel_oe_n=1; panel_row <= row at this edge.
REQ-025 DISPLAY: panel_oe_n=0 for exactly ON_CYCLES cycles; panel_oe_n=1 in all other states.
REQ-026 Row period SHALL be 131+ON_CYCLES cycles (PRE 1, SHIFT 128, TAIL 1, LATCH 1, DISPLAY); frame = 16 rows.
REQ-027 End of DISPLAY, row<15: row increments, next state PRE if enable=1 else IDLE.
REQ-028 End of DISPLAY, row 15: frame_done pulses 1 cycle; row wraps to 0; next state PRE if enable=1 else IDLE.
REQ-029 Swap: if swap_req=1 in the last DISPLAY cycle of row 15, active_buf toggles and swap_ack pulses in the same cycle as frame_done; otherwise no toggle.
REQ-030 swap_req asserted mid-frame SHALL NOT affect rd_addr until the frame boundary; at most one toggle per frame.
REQ-031 enable deasserted mid-row SHALL complete the current row including DISPLAY before IDLE.

Reset
REQ-032 reset_n=0 SHALL immediately force: state IDLE, row 0, col 0, rd_addr 0, rd_en 0, panel_r1/r2/clk/lat 0, panel_oe_n 1, panel_row 0, active_buf 0, swap_ack 0, frame_done 0.
REQ-033 Reset mid-row SHALL abandon the row; after release, scanning restarts at PRE, row 0, buffer 0.

Structure
REQ-034 Package led_scan_pkg SHALL hold the state enumeration, COLS/ROWS constants, and column/row/address widths.
REQ-035 No sub-module; the block sits beside the framebuffer RAM at top level, rd_addr/rd_en/rd_data wired to its read port.

Verification
REQ-036 Reset: hold reset_n=0 -> panel_oe_n=1, all other outputs 0; release with enable=0 -> stays IDLE.
REQ-037 Shift: RAM model col c returns c[1:0], enable=1 -> on panel_clk rise k (k=1..64), {r2,r1}=(k-1)[1:0]; exactly 64 rises, then one lat pulse.
REQ-038 Timing, ON_CYCLES=64: panel_lat pulses 195 cycles apart; panel_oe_n low exactly 64 cycles per row; frame_done every 3120 cycles; panel_row 0..15 then 0.
REQ-039 Swap: swap_req=1 at row 5 -> swap_ack and frame_done coincide at end of row 15; next PRE rd_addr=0x400; swap_req held only 1 cycle mid-frame -> no toggle.
REQ-040 Enable drop during SHIFT of row 3 -> row 3 completes with 64 OE cycles, then IDLE, panel_oe_n=1; re-enable -> PRE at row 4.
REQ-041 Reset mid-SHIFT (column 30) -> outputs reset same cycle; after release first rd_addr=0x000.
